// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of run-time reloadable 50% clock dividers with rising-edge tick strobes
// Optional feature macro CLKDIV_SYNC_EN adds sync_in to phase-align every enabled channel.
module clk_div_bank #(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 28,
  parameter int DEF_HALF0 = 200000000,
  parameter int DEF_HALF  = 10000,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk100MHz,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] cfg_busy,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
`ifdef CLKDIV_SYNC_EN
  ,
  input  logic              sync_in
`endif
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF0 = CNT_W'(DEF_HALF0);
  localparam logic [CNT_W-1:0] DEFN = CNT_W'(DEF_HALF);

  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [CNT_W-1:0]  half_act [NUM_CH];
  logic [CNT_W-1:0]  pend     [NUM_CH];
  logic [CNT_W-1:0]  h_eff    [NUM_CH];
  logic [NUM_CH-1:0] bnd;
  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] apply;
  logic [CNT_W-1:0]  half_norm;
  logic              sync_hit;

`ifdef CLKDIV_SYNC_EN
  assign sync_hit = sync_in;
`else
  assign sync_hit = 1'b0;
`endif

  // A zero half-period behaves as one (divide-by-2), both on write and on use.
  assign half_norm = (cfg_half == '0) ? ONE : cfg_half;

  always_comb begin
    bnd    = '0;
    wr_hit = '0;
    apply  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      h_eff[i]  = (half_act[i] == '0) ? ONE : half_act[i];
      bnd[i]    = en[i] && (cnt[i] == h_eff[i] - ONE);
      wr_hit[i] = cfg_wr && (int'(cfg_ch) == i);
      // Pending values land only where no half-phase is in progress.
      apply[i]  = cfg_busy[i] && (!en[i] || bnd[i] || sync_hit);
    end
  end

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      cfg_busy <= '0;
      clk_out  <= '0;
      tick     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]      <= '0;
        pend[i]     <= '0;
        half_act[i] <= (i == 0) ? DEF0 : DEFN;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!en[i] || sync_hit) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
        end else if (bnd[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= ~clk_out[i];
          tick[i]    <= ~clk_out[i];
        end else begin
          cnt[i]     <= cnt[i] + ONE;
          tick[i]    <= 1'b0;
        end
        if (apply[i]) begin
          half_act[i] <= pend[i];
          cfg_busy[i] <= 1'b0;
        end
        // A coincident write overrides the clear so it waits for the next boundary.
        if (wr_hit[i]) begin
          pend[i]     <= half_norm;
          cfg_busy[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - directed self-checking bench for clk_div_bank
// Reduced build: NUM_CH=3 so cfg_ch=3 is an out-of-range channel; ch0 default half-period 50.
module tb_clk_div_bank;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 28;

  logic              clk100MHz = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] en;
  logic              cfg_wr;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic [NUM_CH-1:0] cfg_busy;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
`ifdef CLKDIV_SYNC_EN
  logic              sync_in;
`endif

  int total = 0;
  int bad   = 0;

  clk_div_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_HALF0(50), .DEF_HALF(10000)
  ) dut (
    .clk100MHz(clk100MHz),
    .rst_n(rst_n),
    .en(en),
    .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch),
    .cfg_half(cfg_half),
    .cfg_busy(cfg_busy),
    .clk_out(clk_out),
    .tick(tick)
`ifdef CLKDIV_SYNC_EN
    ,
    .sync_in(sync_in)
`endif
  );

  always #5 clk100MHz = ~clk100MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk100MHz);
    #1;
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [CNT_W-1:0] half);
    cfg_wr = 1'b1; cfg_ch = ch; cfg_half = half;
    step();
    cfg_wr = 1'b0;
  endtask

  initial begin
    int ch1_first, ch1_second, ch1_ticks, ch0_ticks;
    logic [15:0] pat_clk, pat_tick;
    logic [14:0] p3_clk, p3_tick, p3_busy;
    logic [5:0]  p4_c1, p4_c2;

    rst_n = 1'b0; en = '0; cfg_wr = 1'b0; cfg_ch = '0; cfg_half = '0;
`ifdef CLKDIV_SYNC_EN
    sync_in = 1'b0;
`endif
    step(); step();
    check("reset_clk_out", 32'(clk_out), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_busy", 32'(cfg_busy), 32'h0);

    // Defaults: ch1 H=10000 -> rises at 10000 and 30000; ch0 H=50 -> 300 rises in 30000 cycles.
    rst_n = 1'b1; en = 3'b011;
    ch1_first = -1; ch1_second = -1; ch1_ticks = 0; ch0_ticks = 0;
    for (int c = 1; c <= 30000; c++) begin
      step();
      if (tick[1]) begin
        ch1_ticks++;
        if (ch1_first < 0) ch1_first = c;
        else if (ch1_second < 0) ch1_second = c;
      end
      if (tick[0]) ch0_ticks++;
    end
    check("def_ch1_first_rise", 32'(ch1_first), 32'd10000);
    check("def_ch1_second_rise", 32'(ch1_second), 32'd30000);
    check("def_ch1_tick_count", 32'(ch1_ticks), 32'd2);
    check("def_ch0_tick_count", 32'(ch0_ticks), 32'd300);

    en = '0;
    step();
    check("disable_clk_out", 32'(clk_out), 32'h0);
    check("disable_tick", 32'(tick), 32'h0);

    // Write while disabled applies after one busy cycle; H=3 pattern.
    write_cfg(2'd1, 28'd3);
    check("dis_write_busy_set", 32'(cfg_busy), 32'b010);
    step();
    check("dis_write_busy_clr", 32'(cfg_busy), 32'b000);
    en = 3'b010;
    pat_clk  = 16'b0001110001110001;
    pat_tick = 16'b0001000001000001;
    for (int c = 0; c < 16; c++) begin
      check($sformatf("h3_clk_c%0d", c), 32'(clk_out[1]), 32'(pat_clk[15-c]));
      check($sformatf("h3_tick_c%0d", c), 32'(tick[1]), 32'(pat_tick[15-c]));
      step();
    end

    // H=5 running, write H=2 at counter 1: low phase stays 5, then half-phases of 2.
    en = '0;
    step();
    write_cfg(2'd1, 28'd5);
    step();
    en = 3'b010;
    p3_clk  = 15'b000001100110011;
    p3_tick = 15'b000001000100010;
    p3_busy = 15'b001110000000000;
    for (int c = 0; c < 15; c++) begin
      check($sformatf("reload_clk_c%0d", c), 32'(clk_out[1]), 32'(p3_clk[14-c]));
      check($sformatf("reload_tick_c%0d", c), 32'(tick[1]), 32'(p3_tick[14-c]));
      check($sformatf("reload_busy_c%0d", c), 32'(cfg_busy[1]), 32'(p3_busy[14-c]));
      if (c == 1) begin
        cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_half = 28'd2;
      end
      step();
      cfg_wr = 1'b0;
    end

    // cfg_half=0 on ch2 -> divide-by-2; write to cfg_ch=3 must change nothing.
    en = '0;
    step();
    write_cfg(2'd2, 28'd0);
    step();
    write_cfg(2'd3, 28'd7);
    check("oob_write_busy", 32'(cfg_busy), 32'h0);
    step();
    en = 3'b110;
    p4_c1 = 6'b001100;
    p4_c2 = 6'b010101;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("div2_ch2_clk_c%0d", c), 32'(clk_out[2]), 32'(p4_c2[5-c]));
      check($sformatf("div2_ch2_tick_c%0d", c), 32'(tick[2]), 32'(p4_c2[5-c]));
      check($sformatf("oob_ch1_clk_c%0d", c), 32'(clk_out[1]), 32'(p4_c1[5-c]));
      step();
    end

    // Async reset mid high-phase with a pending write.
    en = '0;
    step();
    en = 3'b010;
    step(); step();
    check("prereset_high", 32'(clk_out[1]), 32'h1);
    write_cfg(2'd1, 28'd9);
    check("prereset_busy", 32'(cfg_busy), 32'b010);
    check("prereset_still_high", 32'(clk_out[1]), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clk_out", 32'(clk_out), 32'h0);
    check("async_reset_busy", 32'(cfg_busy), 32'h0);
    en = '0;
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_busy", 32'(cfg_busy), 32'h0);
    en = 3'b010;
    for (int c = 1; c < 10000; c++) step();
    check("post_reset_ch1_low_at_9999", 32'(clk_out[1]), 32'h0);
    step();
    check("post_reset_ch1_rise_at_10000", 32'(clk_out[1]), 32'h1);
    check("post_reset_ch1_tick_at_10000", 32'(tick[1]), 32'h1);

`ifdef CLKDIV_SYNC_EN
    // ch0 H=4, ch1 H=6 free-running, then sync_in realigns both.
    en = '0;
    step();
    write_cfg(2'd0, 28'd4);
    write_cfg(2'd1, 28'd6);
    step();
    en = 3'b011;
    for (int c = 0; c < 7; c++) step();
    check("presync_ch0_high", 32'(clk_out[0]), 32'h1);
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    check("sync_clk_out", 32'(clk_out[1:0]), 32'h0);
    check("sync_tick", 32'(tick[1:0]), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("sync_ch0_clk_k%0d", k), 32'(clk_out[0]), 32'(k >= 4));
      check($sformatf("sync_ch1_clk_k%0d", k), 32'(clk_out[1]), 32'(k >= 6));
      check($sformatf("sync_ch0_tick_k%0d", k), 32'(tick[0]), 32'(k == 4));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
